// File: rtl/seg_scan_mux_if.sv
// Digit-code inputs and active-low display pins of the segment scan multiplexer.
// master drives the four digit codes and blink mask, and observes the pins.
// slave is the multiplexer: it consumes the codes and drives an/seg/dp.
interface seg_scan_mux_if;
  logic [4:0] min_l;
  logic [4:0] min_r;
  logic [4:0] sec_l;
  logic [4:0] sec_r;
  logic [3:0] blink_mask;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output min_l, min_r, sec_l, sec_r, blink_mask,
    input  an, seg, dp
  );

  modport slave (
    input  min_l, min_r, sec_l, sec_r, blink_mask,
    output an, seg, dp
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Four-digit common-anode 7-segment scanner with frame snapshots, ghost guard and blink.
// Latency: an/seg/dp are registered, one cycle from the next-state slot/ref_cnt values.
// No backpressure: the display free-runs; optional blinking colon on dp under DP_COLON_EN.
module seg_scan_mux #(
  parameter int REFRESH_BITS = 17,  // each slot dwells 2^REFRESH_BITS cycles
  parameter int GUARD        = 4,   // dark cycles at the start of each slot, < 2^REFRESH_BITS
  parameter int BLINK_BITS   = 25   // blink counter width; MSB is the blink phase
) (
  input  logic            clk,
  input  logic            rst,      // synchronous, active-low
  seg_scan_mux_if.slave   bus
);

  localparam logic [4:0] CODE_BLANK = 5'd31;
  localparam logic [6:0] PAT_BLANK  = 7'b1111111;
  localparam logic [6:0] PAT_DASH   = 7'b0111111;

  // Scan state
  logic [REFRESH_BITS-1:0] ref_cnt;
  logic [REFRESH_BITS-1:0] ref_cnt_nxt;
  logic [1:0]              slot;
  logic [1:0]              slot_nxt;
  logic [BLINK_BITS-1:0]   blink_cnt;
  logic [BLINK_BITS-1:0]   blink_cnt_nxt;

  // Frame snapshot, indexed by slot: [0]=sec_r, [1]=sec_l, [2]=min_r, [3]=min_l
  logic [3:0][4:0]         snap;
  logic [3:0][4:0]         snap_nxt;

  // Registered pins
  logic [3:0]              an_q;
  logic [6:0]              seg_q;
  logic                    dp_q;

  // Next pin values
  logic [3:0]              an_nxt;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;

  logic                    slot_end;
  logic                    frame_end;
  logic                    in_guard;
  logic                    blink_off;
  logic                    blink_phase_nxt;
  logic [4:0]              code_nxt;

  // Segment patterns {g,f,e,d,c,b,a}, active-low. 31 is blank, other
  // out-of-range codes show a dash so a corrupt upstream value is visible.
  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] pat;
    case (code)
      5'd0:       pat = 7'b1000000;
      5'd1:       pat = 7'b1111001;
      5'd2:       pat = 7'b0100100;
      5'd3:       pat = 7'b0110000;
      5'd4:       pat = 7'b0011001;
      5'd5:       pat = 7'b0010010;
      5'd6:       pat = 7'b0000010;
      5'd7:       pat = 7'b1111000;
      5'd8:       pat = 7'b0000000;
      5'd9:       pat = 7'b0010000;
      CODE_BLANK: pat = PAT_BLANK;
      default:    pat = PAT_DASH;
    endcase
    return pat;
  endfunction

  // Next-state for the dwell counter, slot index, blink counter and snapshot.
  // The snapshot is taken on the very last cycle of slot 3 so that the
  // whole following frame is built from one coherent set of digits.
  always_comb begin
    slot_end      = &ref_cnt;
    frame_end     = slot_end && (slot == 2'd3);
    ref_cnt_nxt   = ref_cnt + REFRESH_BITS'(1);
    slot_nxt      = slot_end ? slot + 2'd1 : slot;
    blink_cnt_nxt = blink_cnt + BLINK_BITS'(1);
    snap_nxt      = snap;
    if (frame_end) begin
      snap_nxt = {bus.min_l, bus.min_r, bus.sec_l, bus.sec_r};
    end
  end

  // Pin values derived from the next state, so the registered pins line up
  // with the slot/ref_cnt registers that take effect on the same edge.
  always_comb begin
    blink_phase_nxt = blink_cnt_nxt[BLINK_BITS-1];
    in_guard        = (ref_cnt_nxt < REFRESH_BITS'(GUARD));
    blink_off       = bus.blink_mask[slot_nxt] && blink_phase_nxt;
    code_nxt        = snap_nxt[slot_nxt];
    seg_nxt         = decode(code_nxt);
    an_nxt          = 4'b1111;
    if (!in_guard && !blink_off) begin
      an_nxt = ~(4'b0001 << slot_nxt);
    end
`ifdef DP_COLON_EN
    // Colon rides on the min_r digit and blinks with the blink phase.
    dp_nxt = !((slot_nxt == 2'd2) && (an_nxt != 4'b1111) && !blink_phase_nxt);
`else
    dp_nxt = 1'b1;
`endif
  end

  // Scan state and snapshot registers; reset blanks the snapshot so a
  // frame interrupted by reset never shows stale digits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ref_cnt   <= '0;
      slot      <= 2'd0;
      blink_cnt <= '0;
      snap      <= {4{CODE_BLANK}};
    end else begin
      ref_cnt   <= ref_cnt_nxt;
      slot      <= slot_nxt;
      blink_cnt <= blink_cnt_nxt;
      snap      <= snap_nxt;
    end
  end

  // Output pin registers; dark during reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      an_q  <= 4'b1111;
      seg_q <= PAT_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_nxt;
      seg_q <= seg_nxt;
      dp_q  <= dp_nxt;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Downstream consumer of the stopwatch counter's four digit outputs (min_l, min_r, sec_l, sec_r).
- Time-multiplexes the four 5-bit digit codes onto one common-anode 7-segment bus with active-low anode strobes.
- Provides tear-free frame snapshots, an inter-digit ghosting guard and per-digit blink for adjust mode.

Parameters:
- REFRESH_BITS, 17: width of the per-slot dwell counter; each digit is shown for 2^REFRESH_BITS cycles.
- GUARD, 4: cycles at the start of each slot with all anodes off; must be < 2^REFRESH_BITS.
- BLINK_BITS, 25: width of the free-running blink counter; its MSB is the blink phase.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- min_l  in  5  minutes tens digit code.
- min_r  in  5  minutes units digit code.
- sec_l  in  5  seconds tens digit code.
- sec_r  in  5  seconds units digit code.
- blink_mask  in  4  per-slot blink enable; bit i maps to slot i.
- an  out  4  anode strobes, active-low, one-hot when lit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset is sampled only on a clk rising edge; rst==0 loads:
  - ref_cnt=0, slot=0, blink_cnt=0.
  - All four snapshot registers = 31 (blank).
  - an=4'b1111, seg=7'b1111111, dp=1.
- ref_cnt increments every cycle.
  - At all-ones it wraps to 0 and slot advances 0->1->2->3->0.
- Slot map: slot0=sec_r/an[0], slot1=sec_l/an[1], slot2=min_r/an[2], slot3=min_l/an[3].
- Snapshot:
  - All four inputs are captured together on the cycle where slot==3 and ref_cnt is all-ones (frame boundary).
  - The new values are first displayed in slot0 of the next frame.
  - Input changes mid-frame never reach the display.
- Decode of a snapshot code:
  - 0-9 drive the standard digit patterns (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000).
  - 31 drives blank (1111111).
  - 10-30 drive a dash (0111111).
- Anode select, evaluated on the combinational next-state values:
  - an=4'b1111 if ref_cnt < GUARD.
  - an=4'b1111 if blink_mask[slot]==1 and blink_cnt[BLINK_BITS-1]==1.
  - Otherwise an = ~(1<<slot).
  - seg always carries the decoded current-slot pattern, including during guard and blink-off cycles.
- Outputs an, seg and dp are registered: exactly one cycle of latency from the slot/ref_cnt state to the pins.
- blink_cnt free-runs and wraps silently. blink_mask is sampled live every cycle and is not snapshotted.
- rst asserted mid-frame aborts the frame immediately:
  - Outputs go dark on the next edge.
  - Display shows blank until the first frame boundary after release.

Optional Feature:
- DP_COLON_EN defined:
  - dp is driven low (lit) during slot2 (min_r) whenever that slot's anode is lit and blink_cnt[BLINK_BITS-1]==0.
  - This produces a blinking colon; dp=1 in all other cases.
- DP_COLON_EN undefined: dp is tied to 1 after reset.
- Anode and segment behaviour are identical in both builds.

Test Plan (REFRESH_BITS=2, GUARD=1, BLINK_BITS=4):
- Reset held low 3 cycles -> an=1111, seg=1111111, dp=1. First frame after release shows blank on all four slots with an pulsing 1110, 1101, 1011, 0111, 3 lit cycles each, each preceded by 1 dark cycle.
- Inputs min_l=1, min_r=2, sec_l=3, sec_r=4 held -> the second frame shows an=1110/seg=0011001, an=1101/0110000, an=1011/0100100, an=0111/1111001.
- Change sec_r 4->9 during slot1 -> the rest of that frame is unchanged; sec_r=9 (0010000) appears in slot0 of the next frame.
- Codes 12 and 31 on sec_l/sec_r -> dash 0111111 on an[1], blank 1111111 on an[0].
- blink_mask=4'b0001 -> an[0] is lit only while blink_cnt[3]==0; slots 1-3 are unaffected.
- DP_COLON_EN defined -> dp=0 only on lit slot2 cycles with blink_cnt[3]==0. Undefined -> dp stays 1 throughout.
